// File: rtl/id_ex_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : id_ex_reg                                                      |
// | Description: ID/EX pipeline register with operand forwarding, load-use     |
// |              bubble insertion, flush and memory-stall hold.                 |
// |              Optional perf counters enabled by macro ID_EX_PERF_CNT_EN.     |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module id_ex_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_ID,
  input  logic [63:0] pc_ID,
  input  logic [63:0] imm_ID,
  input  logic [4:0]  rs1_addr_ID,
  input  logic [4:0]  rs2_addr_ID,
  input  logic [4:0]  rd_ID_in,
  input  logic        rf_wr_en_in,
  input  logic [2:0]  dm_rd_ctrl_in,
  input  logic [1:0]  dm_wr_ctrl_in,
  input  logic [3:0]  alu_ctrl_in,
  input  logic [63:0] rs1_data_rf,
  input  logic [63:0] rs2_data_rf,
  input  logic [63:0] forward_rs1_data,
  input  logic        forward_rs1_sel,
  input  logic [63:0] forward_rs2_data,
  input  logic        forward_rs2_sel,
  input  logic        flush,
  input  logic        mem_stall,
  output logic        valid_EX,
  output logic [63:0] pc_EX,
  output logic [63:0] imm_EX,
  output logic [63:0] rs1_data_EX,
  output logic [63:0] rs2_data_EX,
  output logic [4:0]  rd_EX,
  output logic        rf_wr_en_EX,
  output logic [2:0]  dm_rd_ctrl_EX,
  output logic [1:0]  dm_wr_ctrl_EX,
  output logic [3:0]  alu_ctrl_EX,
`ifdef ID_EX_PERF_CNT_EN
  output logic        stall_ID,
  output logic [31:0] bubble_cnt,
  output logic [31:0] stall_cnt
`else
  output logic        stall_ID
`endif
);

  localparam logic [0:0] c_RUN    = 1'b0;
  localparam logic [0:0] c_BUBBLE = 1'b1;

  logic [0:0]  r_state;
  logic [0:0]  w_state_next;
  logic        w_load_use;
  logic        w_bubble;
  logic [63:0] w_rs1_op;
  logic [63:0] w_rs2_op;

  logic        r_valid;
  logic [63:0] r_pc;
  logic [63:0] r_imm;
  logic [63:0] r_rs1;
  logic [63:0] r_rs2;
  logic [4:0]  r_rd;
  logic        r_wr_en;
  logic [2:0]  r_rd_ctrl;
  logic [1:0]  r_wr_ctrl;
  logic [3:0]  r_alu;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_RUN;
    else     r_state <= w_state_next;
  end

  // Next-state: flush > mem_stall (hold) > load_use > run
  always_comb begin
    w_state_next = r_state;
    if (flush)           w_state_next = c_RUN;
    else if (mem_stall)  w_state_next = r_state;
    else if (w_load_use) w_state_next = c_BUBBLE;
    else                 w_state_next = c_RUN;
  end

  // In BUBBLE the load has moved on to MEM, so no second hazard is raised
  always_comb begin
    w_load_use = (r_state == c_RUN) && valid_ID && r_valid &&
                 (r_rd_ctrl != 3'd0) && (r_rd != 5'd0) &&
                 ((rs1_addr_ID == r_rd) || (rs2_addr_ID == r_rd));
    stall_ID   = (mem_stall || w_load_use) && !flush && !rst;
  end

  assign w_bubble = flush || (!mem_stall && w_load_use);

  // x0 always reads as zero, whatever the forwarding unit says
  assign w_rs1_op = (rs1_addr_ID == 5'd0) ? 64'h0 :
                    (forward_rs1_sel ? forward_rs1_data : rs1_data_rf);
  assign w_rs2_op = (rs2_addr_ID == 5'd0) ? 64'h0 :
                    (forward_rs2_sel ? forward_rs2_data : rs2_data_rf);

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_valid   <= 1'b0;
      r_pc      <= 64'h0;
      r_imm     <= 64'h0;
      r_rs1     <= 64'h0;
      r_rs2     <= 64'h0;
      r_rd      <= 5'd0;
      r_wr_en   <= 1'b0;
      r_rd_ctrl <= 3'd0;
      r_wr_ctrl <= 2'd0;
      r_alu     <= 4'd0;
    end else if (!mem_stall) begin
      r_valid   <= valid_ID;
      r_pc      <= pc_ID;
      r_imm     <= imm_ID;
      r_rs1     <= w_rs1_op;
      r_rs2     <= w_rs2_op;
      r_rd      <= rd_ID_in;
      r_wr_en   <= rf_wr_en_in;
      r_rd_ctrl <= dm_rd_ctrl_in;
      r_wr_ctrl <= dm_wr_ctrl_in;
      r_alu     <= alu_ctrl_in;
    end
  end

  assign valid_EX      = r_valid;
  assign pc_EX         = r_pc;
  assign imm_EX        = r_imm;
  assign rs1_data_EX   = r_rs1;
  assign rs2_data_EX   = r_rs2;
  assign rd_EX         = r_rd;
  assign rf_wr_en_EX   = r_wr_en;
  assign dm_rd_ctrl_EX = r_rd_ctrl;
  assign dm_wr_ctrl_EX = r_wr_ctrl;
  assign alu_ctrl_EX   = r_alu;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  // Only bubbles actually inserted by a load-use hazard are counted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= 32'd0;
      r_stall_cnt  <= 32'd0;
    end else begin
      if (!flush && !mem_stall && w_load_use) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (!flush && mem_stall)                r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule
`default_nettype wire
